operand_prefetch_ctrl: RTL and testbench

//  Multi-channel successor to the single A/B systolic controller. For NUM_CH operand streams it

---
 rtl/prefetch_pkg.sv | 23 ++
 rtl/operand_channel_ctrl.sv | 74 +++++++
 rtl/operand_prefetch_ctrl.sv | 134 +++++++++++++
 tb/tb_operand_prefetch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the multi-channel operand prefetch controller.
package prefetch_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, RUN, FINISH} pf_state_t;

  localparam int BUS_STEP = 32;
  localparam int THR_W    = 32;

  // Threshold actually used for readiness: zero selects half the transfer (at least one word),
  // and nothing may exceed the transfer length or the channel could never become ready.
  function automatic logic [THR_W-1:0] thr_eff(input logic [THR_W-1:0] words,
                                               input logic [THR_W-1:0] thresh);
    logic [THR_W-1:0] t;
    t = thresh;
    if (t == '0) begin
      t = words >> 1;
      if (t == '0) t = THR_W'(1);
    end
    if (t > words) t = words;
    return t;
  endfunction

endpackage

// File: rtl/operand_channel_ctrl.sv
// One operand channel: config latch, fetch address issue, buffer write tracking, ready flag.
module operand_channel_ctrl
  import prefetch_pkg::*;
#(
  parameter int ADDR_W               = 16,
  parameter int CNT_W                = 16,
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int BUS_WIDTH_BYTES      = BUS_STEP
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            load,
  input  logic                            clear,
  input  logic                            active,
  input  logic                            abort,
  input  logic [ADDR_W-1:0]               base,
  input  logic [CNT_W-1:0]                words,
  input  logic [CNT_W-1:0]                thresh,
  input  logic                            fifo_full,
  input  logic                            valid_data,
  output logic [ADDR_W-1:0]               fifo_addr,
  output logic                            fifo_incr,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] buffer_addr,
  output logic                            ready
);

  logic [CNT_W-1:0]                words_reg;
  logic [CNT_W-1:0]                thr_reg;
  logic [CNT_W-1:0]                issued_reg;
  logic [CNT_W-1:0]                received_reg;
  logic [ADDR_W-1:0]               addr_reg;
  logic [BUFFER_ADDRESS_WIDTH-1:0] buf_addr_reg;
  logic                            accept_data;

  assign fifo_incr   = active & ~abort & ~fifo_full & (issued_reg < words_reg);
  assign accept_data = active & valid_data & (received_reg < words_reg);
  assign fifo_addr   = addr_reg;
  assign buffer_addr = buf_addr_reg;
  assign ready       = received_reg >= thr_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_reg    <= '0;
      thr_reg      <= '0;
      issued_reg   <= '0;
      received_reg <= '0;
      addr_reg     <= '0;
      buf_addr_reg <= '0;
    end else if (load) begin
      words_reg    <= words;
      thr_reg      <= CNT_W'(thr_eff(THR_W'(words), THR_W'(thresh)));
      issued_reg   <= '0;
      received_reg <= '0;
      addr_reg     <= base;
      buf_addr_reg <= '0;
    end else if (clear) begin
      issued_reg   <= '0;
      received_reg <= '0;
      addr_reg     <= '0;
      buf_addr_reg <= '0;
    end else begin
      // Issue and buffer tracking are independent and may both advance in one cycle.
      if (fifo_incr) begin
        issued_reg <= issued_reg + CNT_W'(1);
        addr_reg   <= addr_reg + ADDR_W'(BUS_WIDTH_BYTES);
      end
      if (accept_data) begin
        received_reg <= received_reg + CNT_W'(1);
        buf_addr_reg <= buf_addr_reg + BUFFER_ADDRESS_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/operand_prefetch_ctrl.sv
// Multi-channel operand prefetch controller: sequencing FSM plus NUM_CH channel trackers.
module operand_prefetch_ctrl
  import prefetch_pkg::*;
#(
  parameter int NUM_CH               = 2,
  parameter int ADDR_W               = 16,
  parameter int BUS_WIDTH_BYTES      = BUS_STEP,
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int CNT_W                = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start_i,
  input  logic                                   abort_i,
  input  logic [NUM_CH*ADDR_W-1:0]               ch_base,
  input  logic [NUM_CH*CNT_W-1:0]                ch_words,
  input  logic [NUM_CH*CNT_W-1:0]                ch_thresh,
  output logic [NUM_CH*ADDR_W-1:0]               fifo_addr,
  output logic [NUM_CH-1:0]                      fifo_incr,
  input  logic [NUM_CH-1:0]                      fifo_full,
  input  logic [NUM_CH-1:0]                      valid_data,
  output logic [NUM_CH*BUFFER_ADDRESS_WIDTH-1:0] buffer_addr,
  output logic                                   array_start,
  input  logic                                   data_done,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  pf_state_t         state_reg, state_next;
  logic              array_start_reg, array_start_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              load, clear;
  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] words_nz;

  assign busy        = (state_reg != IDLE);
  assign array_start = array_start_reg;
  assign done        = done_reg;
  assign err         = err_reg;

  always_comb begin
    state_next       = state_reg;
    array_start_next = array_start_reg;
    done_next        = 1'b0;
    err_next         = err_reg;
    load             = 1'b0;
    clear            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i && !abort_i) begin
          if (&words_nz) begin
            load       = 1'b1;
            err_next   = 1'b0;
            state_next = FETCH;
          end else begin
            err_next  = 1'b1;
            done_next = 1'b1;
          end
        end
      end
      FETCH: begin
        if (&ready) begin
          state_next       = RUN;
          array_start_next = 1'b1;
        end
      end
      RUN: begin
        if (data_done) begin
          state_next = FINISH;
          done_next  = 1'b1;
        end
      end
      FINISH: begin
        clear            = 1'b1;
        array_start_next = 1'b0;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides every other transition, including a simultaneous data_done.
    if (abort_i && state_reg != IDLE) begin
      state_next       = IDLE;
      array_start_next = 1'b0;
      done_next        = 1'b0;
      clear            = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      array_start_reg <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      array_start_reg <= array_start_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign words_nz[gi] = (ch_words[gi*CNT_W +: CNT_W] != '0);

      operand_channel_ctrl #(
        .ADDR_W              (ADDR_W),
        .CNT_W               (CNT_W),
        .BUFFER_ADDRESS_WIDTH(BUFFER_ADDRESS_WIDTH),
        .BUS_WIDTH_BYTES     (BUS_WIDTH_BYTES)
      ) u_ch (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .clear      (clear),
        .active     (busy),
        .abort      (abort_i),
        .base       (ch_base[gi*ADDR_W +: ADDR_W]),
        .words      (ch_words[gi*CNT_W +: CNT_W]),
        .thresh     (ch_thresh[gi*CNT_W +: CNT_W]),
        .fifo_full  (fifo_full[gi]),
        .valid_data (valid_data[gi]),
        .fifo_addr  (fifo_addr[gi*ADDR_W +: ADDR_W]),
        .fifo_incr  (fifo_incr[gi]),
        .buffer_addr(buffer_addr[gi*BUFFER_ADDRESS_WIDTH +: BUFFER_ADDRESS_WIDTH]),
        .ready      (ready[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_operand_prefetch_ctrl.sv
// Directed table-driven bench for operand_prefetch_ctrl (two channels, 3-bit buffer address).
module tb_operand_prefetch_ctrl;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 16;
  localparam int BWB    = 32;
  localparam int BAW    = 3;
  localparam int CNT_W  = 16;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      start_i = 1'b0;
  logic                      abort_i = 1'b0;
  logic                      data_done = 1'b0;
  logic [NUM_CH*ADDR_W-1:0]  ch_base = '0;
  logic [NUM_CH*CNT_W-1:0]   ch_words = '0;
  logic [NUM_CH*CNT_W-1:0]   ch_thresh = '0;
  logic [NUM_CH*ADDR_W-1:0]  fifo_addr;
  logic [NUM_CH-1:0]         fifo_incr;
  logic [NUM_CH-1:0]         fifo_full = '0;
  logic [NUM_CH-1:0]         valid_data = '0;
  logic [NUM_CH*BAW-1:0]     buffer_addr;
  logic                      array_start, busy, done, err;

  operand_prefetch_ctrl #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BUS_WIDTH_BYTES(BWB),
    .BUFFER_ADDRESS_WIDTH(BAW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
    .ch_base(ch_base), .ch_words(ch_words), .ch_thresh(ch_thresh),
    .fifo_addr(fifo_addr), .fifo_incr(fifo_incr), .fifo_full(fifo_full),
    .valid_data(valid_data), .buffer_addr(buffer_addr), .array_start(array_start),
    .data_done(data_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Configuration sets: base0, base1, words0, words1, thresh0, thresh1
  logic [15:0] cfg_b0 [5] = '{16'h100, 16'h100, 16'h100, 16'h100, 16'h100};
  logic [15:0] cfg_b1 [5] = '{16'h400, 16'h400, 16'h400, 16'h400, 16'h400};
  logic [15:0] cfg_w0 [5] = '{16'd4, 16'd4, 16'd4, 16'd8, 16'd10};
  logic [15:0] cfg_w1 [5] = '{16'd4, 16'd4, 16'd0, 16'd8, 16'd10};
  logic [15:0] cfg_t0 [5] = '{16'd0, 16'd3, 16'd0, 16'd0, 16'd0};
  logic [15:0] cfg_t1 [5] = '{16'd0, 16'd1, 16'd0, 16'd0, 16'd0};

  typedef struct {
    int          cfg;
    logic        st, ab, dd;
    logic [1:0]  vd, fl;
    logic [1:0]  e_incr;
    logic [15:0] e_a0, e_a1;
    logic [2:0]  e_b0, e_b1;
    logic        e_as, e_busy, e_done, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(int cfg, logic st, logic ab, logic dd, logic [1:0] vd, logic [1:0] fl,
                             logic [1:0] incr, logic [15:0] a0, logic [15:0] a1,
                             logic [2:0] b0, logic [2:0] b1, logic as_e, logic bz, logic dn, logic er);
    vec_t r;
    r.cfg = cfg; r.st = st; r.ab = ab; r.dd = dd; r.vd = vd; r.fl = fl;
    r.e_incr = incr; r.e_a0 = a0; r.e_a1 = a1; r.e_b0 = b0; r.e_b1 = b1;
    r.e_as = as_e; r.e_busy = bz; r.e_done = dn; r.e_err = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int id);
    ch_base   = {cfg_b1[id], cfg_b0[id]};
    ch_words  = {cfg_w1[id], cfg_w0[id]};
    ch_thresh = {cfg_t1[id], cfg_t0[id]};
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, ".fifo_incr"},    32'(fifo_incr), 32'(e.e_incr));
    check({tag, ".fifo_addr0"},   32'(fifo_addr[15:0]), 32'(e.e_a0));
    check({tag, ".fifo_addr1"},   32'(fifo_addr[31:16]), 32'(e.e_a1));
    check({tag, ".buffer_addr0"}, 32'(buffer_addr[2:0]), 32'(e.e_b0));
    check({tag, ".buffer_addr1"}, 32'(buffer_addr[5:3]), 32'(e.e_b1));
    check({tag, ".array_start"},  32'(array_start), 32'(e.e_as));
    check({tag, ".busy"},         32'(busy), 32'(e.e_busy));
    check({tag, ".done"},         32'(done), 32'(e.e_done));
    check({tag, ".err"},          32'(err), 32'(e.e_err));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t z;
    int   iss0, iss1, rec;
    logic e0, e1;

    // Test 1: basic two-channel fetch, threshold 2, completion
    vecs.push_back(v(0,1,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 3,16'h100,16'h400,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,3,0, 3,16'h120,16'h420,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,3,0, 3,16'h140,16'h440,1,1,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 3,16'h160,16'h460,2,2,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 0,16'h180,16'h480,2,2,1,1,0,0));
    vecs.push_back(v(0,0,0,0,3,0, 0,16'h180,16'h480,2,2,1,1,0,0));
    vecs.push_back(v(0,0,0,1,0,0, 0,16'h180,16'h480,3,3,1,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 0,16'h180,16'h480,3,3,1,1,1,0));
    vecs.push_back(v(0,0,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0));
    // Test 6: uneven thresholds, ch1 first, start ignored during RUN
    vecs.push_back(v(1,1,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,2,0, 3,16'h100,16'h400,0,0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,1,0, 3,16'h120,16'h420,0,1,0,1,0,0));
    vecs.push_back(v(1,0,0,0,1,0, 3,16'h140,16'h440,1,1,0,1,0,0));
    vecs.push_back(v(1,0,0,0,1,0, 3,16'h160,16'h460,2,1,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0, 0,16'h180,16'h480,3,1,0,1,0,0));
    vecs.push_back(v(1,1,0,0,0,0, 0,16'h180,16'h480,3,1,1,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0, 0,16'h180,16'h480,3,1,1,1,0,0));
    vecs.push_back(v(1,0,0,1,0,0, 0,16'h180,16'h480,3,1,1,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0, 0,16'h180,16'h480,3,1,1,1,1,0));
    vecs.push_back(v(1,0,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0));
    // Test 5: abort together with data_done in RUN
    vecs.push_back(v(0,1,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,3,0, 3,16'h100,16'h400,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,3,0, 3,16'h120,16'h420,1,1,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 3,16'h140,16'h440,2,2,0,1,0,0));
    vecs.push_back(v(0,0,1,1,0,0, 0,16'h160,16'h460,2,2,1,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0));
    // Test 3: zero word count rejected, then a valid start clears err
    vecs.push_back(v(2,1,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0));
    vecs.push_back(v(2,0,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,1,1));
    vecs.push_back(v(2,0,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,1));
    vecs.push_back(v(0,1,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,1));
    vecs.push_back(v(0,0,1,0,0,0, 0,16'h100,16'h400,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    z = v(0,0,0,0,0,0, 0,16'h000,16'h000,0,0,0,0,0,0);
    check_all("reset", z);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      set_cfg(vecs[i].cfg);
      start_i    = vecs[i].st;
      abort_i    = vecs[i].ab;
      data_done  = vecs[i].dd;
      valid_data = vecs[i].vd;
      fifo_full  = vecs[i].fl;
      @(negedge clk);
      $display("vec %0d: st=%0b ab=%0b dd=%0b vd=%b incr=%b a0=%h a1=%h b0=%0d b1=%0d as=%0b busy=%0b done=%0b err=%0b",
               i, start_i, abort_i, data_done, valid_data, fifo_incr, fifo_addr[15:0], fifo_addr[31:16],
               buffer_addr[2:0], buffer_addr[5:3], array_start, busy, done, err);
      check_all($sformatf("vec%0d", i), vecs[i]);
      next_cycle();
    end
    start_i = 0; abort_i = 0; data_done = 0; valid_data = 0; fifo_full = 0;

    // Test 2: ch1 FIFO full for 5 cycles; address sequence must not skip or repeat
    set_cfg(3);
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    iss0 = 0;
    iss1 = 0;
    for (int i = 0; i < 14; i++) begin
      fifo_full = (i >= 2 && i < 7) ? 2'b10 : 2'b00;
      @(negedge clk);
      e0 = (iss0 < 8);
      e1 = !(i >= 2 && i < 7) && (iss1 < 8);
      $display("t2 cyc %0d: full=%b incr=%b a0=%h a1=%h", i, fifo_full, fifo_incr,
               fifo_addr[15:0], fifo_addr[31:16]);
      check($sformatf("t2.incr0[%0d]", i), 32'(fifo_incr[0]), 32'(e0));
      check($sformatf("t2.incr1[%0d]", i), 32'(fifo_incr[1]), 32'(e1));
      check($sformatf("t2.addr0[%0d]", i), 32'(fifo_addr[15:0]), 32'(16'(32'h100 + iss0 * 32)));
      check($sformatf("t2.addr1[%0d]", i), 32'(fifo_addr[31:16]), 32'(16'(32'h400 + iss1 * 32)));
      if (e0) iss0++;
      if (e1) iss1++;
      next_cycle();
    end
    fifo_full = 2'b00;
    abort_i = 1'b1;
    next_cycle();
    abort_i = 1'b0;
    @(negedge clk);
    check("t2.busy_after_abort", 32'(busy), 32'd0);
    next_cycle();

    // Test 4: 3-bit buffer address wraps, 11th word ignored
    set_cfg(4);
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    rec = 0;
    for (int i = 0; i < 11; i++) begin
      valid_data = 2'b11;
      @(negedge clk);
      $display("t4 word %0d: b0=%0d b1=%0d", i, buffer_addr[2:0], buffer_addr[5:3]);
      check($sformatf("t4.buf0[%0d]", i), 32'(buffer_addr[2:0]), 32'(rec % 8));
      check($sformatf("t4.buf1[%0d]", i), 32'(buffer_addr[5:3]), 32'(rec % 8));
      if (rec < 10) rec++;
      next_cycle();
    end
    valid_data = 2'b00;
    @(negedge clk);
    check("t4.buf0_final", 32'(buffer_addr[2:0]), 32'd2);
    check("t4.buf1_final", 32'(buffer_addr[5:3]), 32'd2);
    check("t4.array_start", 32'(array_start), 32'd1);
    next_cycle();
    abort_i = 1'b1;
    next_cycle();
    abort_i = 1'b0;
    @(negedge clk);
    check("t4.busy_after_abort", 32'(busy), 32'd0);
    check("t4.buf0_cleared", 32'(buffer_addr[2:0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
